// File: rtl/wb_xbar_pkg.sv
// Shared types and helpers for the Wishbone crossbar (wb_xbar).
// Holds the arbiter state encoding and the round-robin search function.
package wb_xbar_pkg;

  // Arbiter / transfer state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } xbar_state_t;

  // Widest master count supported; index fields are sized for it
  localparam int MAX_M = 8;

  // First requester searching upward (wrapping at n) from last + 1.
  // The loop walks offsets from far to near so the nearest requester is the
  // last assignment and therefore wins. Returns last when nobody requests.
  function automatic logic [2:0] rr_next(input logic [MAX_M-1:0] req,
                                         input logic [2:0]       last,
                                         input int               n);
    logic [2:0] res;
    int         idx;
    res = last;
    for (int i = n; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= n) idx = idx - n;
      if (req[idx[2:0]]) res = idx[2:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin grant register for wb_xbar.
// Loads a one-hot grant when asked and remembers the last granted index so the
// next search starts just above it.
module wb_rr_arbiter
  import wb_xbar_pkg::*;
#(
  parameter int NUM_M = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NUM_M-1:0] req,
  input  logic             load,
  input  logic             clear,
  output logic [NUM_M-1:0] grant
);

  logic [2:0]       last_idx;
  logic [2:0]       next_idx;
  logic [MAX_M-1:0] req_ext;
  logic [NUM_M-1:0] next_oh;

  // Widen the request vector to the fixed width the search function expects
  always_comb begin
    req_ext = '0;
    req_ext[NUM_M-1:0] = req;
  end

  assign next_idx = rr_next(req_ext, last_idx, NUM_M);

  // One-hot form of the winning index
  always_comb begin
    next_oh = '0;
    for (int i = 0; i < NUM_M; i++) next_oh[i] = (next_idx == 3'(i));
  end

  // Grant and last-index registers; reset points last at the top index so the
  // first search after reset starts from master 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant    <= '0;
      last_idx <= 3'(NUM_M - 1);
    end else if (load) begin
      grant    <= next_oh;
      last_idx <= next_idx;
    end else if (clear) begin
      grant    <= '0;
    end
  end

endmodule

// File: rtl/wb_xbar.sv
// Wishbone crossbar: NUM_M masters share one bus to NUM_S address-decoded slaves.
// Round-robin arbitration, zero-latency ack/data return, error on unmapped
// addresses. Optional ack watchdog enabled by defining WB_XBAR_TIMEOUT_EN.
module wb_xbar
  import wb_xbar_pkg::*;
#(
  parameter int NUM_M    = 4,
  parameter int NUM_S    = 8,
  parameter int AW       = 14,
  parameter int DW       = 16,
  parameter int S_ADDR_W = 4,
  parameter logic [NUM_S*S_ADDR_W-1:0] S_BASE =
    {4'hE, 4'hC, 4'hA, 4'h8, 4'h6, 4'h4, 4'h2, 4'h0},
  parameter int TIMEOUT  = 255,
  localparam int SW      = DW / 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_M*AW-1:0] m_adr_i,
  input  logic [NUM_M*DW-1:0] m_dat_i,
  input  logic [NUM_M*SW-1:0] m_sel_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M-1:0]    m_cyc_i,
  input  logic [NUM_M-1:0]    m_stb_i,
  output logic [NUM_M*DW-1:0] m_dat_o,
  output logic [NUM_M-1:0]    m_ack_o,
  output logic [NUM_M-1:0]    m_err_o,
  output logic [AW-1:0]       s_adr_o,
  output logic [DW-1:0]       s_dat_o,
  output logic [SW-1:0]       s_sel_o,
  output logic                s_we_o,
  output logic [NUM_S-1:0]    s_cyc_o,
  output logic [NUM_S-1:0]    s_stb_o,
  input  logic [NUM_S*DW-1:0] s_dat_i,
  input  logic [NUM_S-1:0]    s_ack_i,
  output logic [NUM_M-1:0]    grant_o
);

  xbar_state_t      state, state_nx;
  logic [NUM_M-1:0] grant;
  logic             busy, tmo_fire, hit, sel_ack;
  logic [AW-1:0]    g_adr;
  logic [DW-1:0]    g_dat, sel_dat;
  logic [SW-1:0]    g_sel;
  logic             g_we, g_cyc, g_stb;
  logic [NUM_S-1:0] sel_oh;

  assign busy = (state == BUSY);

  // Arbiter loads a grant from IDLE and drops it whenever we fall back to IDLE
  wb_rr_arbiter #(.NUM_M(NUM_M)) u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    (m_cyc_i),
    .load   ((state == IDLE) && (|m_cyc_i)),
    .clear  ((state != IDLE) && (state_nx == IDLE)),
    .grant  (grant)
  );

  // Mux the granted master onto the shared request; all zero with no grant
  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant[i]) begin
        g_adr = m_adr_i[i*AW +: AW];
        g_dat = m_dat_i[i*DW +: DW];
        g_sel = m_sel_i[i*SW +: SW];
        g_we  = m_we_i[i];
        g_cyc = m_cyc_i[i];
        g_stb = m_stb_i[i];
      end
    end
  end

  // Address decode on the top bits; walking downward lets the lowest slave win
  always_comb begin
    sel_oh = '0;
    for (int k = NUM_S - 1; k >= 0; k--) begin
      if (g_adr[AW-1 -: S_ADDR_W] == S_BASE[k*S_ADDR_W +: S_ADDR_W]) begin
        sel_oh    = '0;
        sel_oh[k] = 1'b1;
      end
    end
  end

  assign hit     = |sel_oh;
  assign sel_ack = busy && (|(sel_oh & s_ack_i));

  // Read data from the selected slave
  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < NUM_S; k++) begin
      if (sel_oh[k]) sel_dat = s_dat_i[k*DW +: DW];
    end
  end

`ifdef WB_XBAR_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign tmo_fire = busy && g_stb && !sel_ack && (wd_cnt == 16'(TIMEOUT - 1));

  // Watchdog counts stalled strobe cycles; any ack, idle strobe or exit from BUSY restarts it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= '0;
    end else if (!busy || !g_stb || sel_ack || tmo_fire) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  // No watchdog: a stalled slave holds the bus; the term is constant zero
  assign tmo_fire = 1'b0 & (TIMEOUT > 0);
`endif

  // Transfer FSM next state; losing cyc always wins, then decode error, then timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|m_cyc_i) state_nx = BUSY;
      BUSY: begin
        if (!g_cyc)              state_nx = IDLE;
        else if (g_stb && !hit)  state_nx = ERR;
        else if (tmo_fire)       state_nx = ERR;
      end
      ERR:     state_nx = g_cyc ? BUSY : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Slave-side outputs; strobes only reach the selected slave while BUSY
  assign s_adr_o = g_adr;
  assign s_dat_o = g_dat;
  assign s_sel_o = g_sel;
  assign s_we_o  = g_we;
  assign s_cyc_o = (busy && g_cyc) ? sel_oh : '0;
  assign s_stb_o = (busy && g_stb) ? sel_oh : '0;

  // Master-side responses; ack only in BUSY and err only in ERR, so never both
  assign m_ack_o = sel_ack ? grant : '0;
  assign m_err_o = (state == ERR) ? grant : '0;
  assign grant_o = grant;

  // Read data goes to the granted master only
  always_comb begin
    m_dat_o = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (busy && grant[i]) m_dat_o[i*DW +: DW] = sel_dat;
    end
  end

endmodule

// File: tb/tb_wb_xbar.sv
// Directed testbench for wb_xbar (4 masters, 8 slaves, slave 3 base moved to
// 4'hF so 0x1800 is unmapped, TIMEOUT = 8). Expectations follow the
// WB_XBAR_TIMEOUT_EN setting of the build.
module tb_wb_xbar;

  localparam int NUM_M = 4;
  localparam int NUM_S = 8;
  localparam int AW    = 14;
  localparam int DW    = 16;
  localparam int SW    = 2;

  logic                clk;
  logic                resetn;
  logic [NUM_M*AW-1:0] m_adr_i;
  logic [NUM_M*DW-1:0] m_dat_i;
  logic [NUM_M*SW-1:0] m_sel_i;
  logic [NUM_M-1:0]    m_we_i, m_cyc_i, m_stb_i;
  logic [NUM_M*DW-1:0] m_dat_o;
  logic [NUM_M-1:0]    m_ack_o, m_err_o, grant_o;
  logic [AW-1:0]       s_adr_o;
  logic [DW-1:0]       s_dat_o;
  logic [SW-1:0]       s_sel_o;
  logic                s_we_o;
  logic [NUM_S-1:0]    s_cyc_o, s_stb_o;
  logic [NUM_S*DW-1:0] s_dat_i;
  logic [NUM_S-1:0]    s_ack_i;

  int  vectors    = 0;
  int  miscompares = 0;
  logic err_seen;

  wb_xbar #(
    .NUM_M    (NUM_M),
    .NUM_S    (NUM_S),
    .AW       (AW),
    .DW       (DW),
    .S_ADDR_W (4),
    .S_BASE   ({4'hE, 4'hC, 4'hA, 4'h8, 4'hF, 4'h4, 4'h2, 4'h0}),
    .TIMEOUT  (8)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_sel_i (m_sel_i),
    .m_we_i  (m_we_i),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_we_o  (s_we_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .grant_o (grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one master's request fields
  task automatic applyStimulus(input int m, input logic cyc, input logic stb,
                               input logic we, input logic [AW-1:0] adr,
                               input logic [DW-1:0] dat);
    m_cyc_i[m]           = cyc;
    m_stb_i[m]           = stb;
    m_we_i[m]            = we;
    m_adr_i[m*AW +: AW]  = adr;
    m_dat_i[m*DW +: DW]  = dat;
    m_sel_i[m*SW +: SW]  = 2'b11;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Advance to just after the next rising edge
  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    resetn  = 1'b0;
    m_adr_i = '0;
    m_dat_i = '0;
    m_sel_i = '0;
    m_we_i  = '0;
    m_cyc_i = '0;
    m_stb_i = '0;
    s_ack_i = '0;
    for (int k = 0; k < NUM_S; k++) s_dat_i[k*DW +: DW] = 16'h1100 + 16'(k);
    #2;
    checkOutput("reset_grant", 32'(grant_o), 32'h0);
    checkOutput("reset_ack",   32'(m_ack_o), 32'h0);
    checkOutput("reset_err",   32'(m_err_o), 32'h0);
    checkOutput("reset_stb",   32'(s_stb_o), 32'h0);
    checkOutput("reset_cyc",   32'(s_cyc_o), 32'h0);
    nextCycle();
    resetn = 1'b1;

    // Masters 0 and 2 request together: 0 first, 2 two edges after 0 drops
    $display("[TB] round-robin after reset");
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 14'h0000, 16'h0);
    applyStimulus(2, 1'b1, 1'b0, 1'b0, 14'h0000, 16'h0);
    #1 checkOutput("rr_idle_grant", 32'(grant_o), 32'h0);
    nextCycle();
    checkOutput("rr_grant_m0", 32'(grant_o), 32'h1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 14'h0000, 16'h0);
    #1 checkOutput("rr_hold_m0", 32'(grant_o), 32'h1);
    nextCycle();
    checkOutput("rr_release", 32'(grant_o), 32'h0);
    nextCycle();
    checkOutput("rr_grant_m2", 32'(grant_o), 32'h4);
    applyStimulus(2, 1'b0, 1'b0, 1'b0, 14'h0000, 16'h0);
    nextCycle();

    // Master 1 reads 0x2804 -> slave 5, zero-latency ack and data
    $display("[TB] decode and read return");
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 14'h2804, 16'h0);
    nextCycle();
    checkOutput("rd_grant_m1", 32'(grant_o), 32'h2);
    checkOutput("rd_stb",      32'(s_stb_o), 32'h20);
    checkOutput("rd_cyc",      32'(s_cyc_o), 32'h20);
    checkOutput("rd_adr",      32'(s_adr_o), 32'h2804);
    checkOutput("rd_noack",    32'(m_ack_o), 32'h0);
    s_ack_i[5] = 1'b1;
    s_dat_i[5*DW +: DW] = 16'hBEEF;
    #1;
    checkOutput("rd_data_m1", 32'(m_dat_o[1*DW +: DW]), 32'hBEEF);
    checkOutput("rd_ack_m1",  32'(m_ack_o), 32'h2);
    checkOutput("rd_data_m0", 32'(m_dat_o[0*DW +: DW]), 32'h0);
    checkOutput("rd_err",     32'(m_err_o), 32'h0);
    nextCycle();
    s_ack_i[5] = 1'b0;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 14'h0000, 16'h0);
    nextCycle();

    // Master 3 writes unmapped 0x1800 -> one-cycle error, no strobe, no ack
    $display("[TB] unmapped write");
    applyStimulus(3, 1'b1, 1'b1, 1'b1, 14'h1800, 16'h1234);
    nextCycle();
    checkOutput("um_grant_m3", 32'(grant_o), 32'h8);
    checkOutput("um_stb",      32'(s_stb_o), 32'h0);
    checkOutput("um_we",       32'(s_we_o),  32'h1);
    checkOutput("um_dat",      32'(s_dat_o), 32'h1234);
    checkOutput("um_sel",      32'(s_sel_o), 32'h3);
    checkOutput("um_err_busy", 32'(m_err_o), 32'h0);
    nextCycle();
    checkOutput("um_err",     32'(m_err_o), 32'h8);
    checkOutput("um_ack",     32'(m_ack_o), 32'h0);
    checkOutput("um_stb_err", 32'(s_stb_o), 32'h0);
    applyStimulus(3, 1'b1, 1'b0, 1'b1, 14'h1800, 16'h1234);
    nextCycle();
    checkOutput("um_err_once", 32'(m_err_o), 32'h0);
    applyStimulus(3, 1'b0, 1'b0, 1'b0, 14'h0000, 16'h0);
    nextCycle();

    // Master 0 reads slave 0, which never acks
    $display("[TB] stalled slave");
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 14'h0010, 16'h0);
    nextCycle();
    for (int c = 1; c <= 8; c++) begin
      checkOutput($sformatf("wd_noerr_c%0d", c), 32'(m_err_o), 32'h0);
      checkOutput($sformatf("wd_stb_c%0d", c),   32'(s_stb_o), 32'h1);
      nextCycle();
    end
`ifdef WB_XBAR_TIMEOUT_EN
    checkOutput("wd_err_c9", 32'(m_err_o), 32'h1);
    checkOutput("wd_stb_c9", 32'(s_stb_o), 32'h0);
    checkOutput("wd_ack_c9", 32'(m_ack_o), 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 14'h0010, 16'h0);
    nextCycle();
    checkOutput("wd_err_once", 32'(m_err_o), 32'h0);
`else
    err_seen = 1'b0;
    for (int c = 9; c <= 1000; c++) begin
      err_seen = err_seen | (|m_err_o);
      nextCycle();
    end
    checkOutput("wd_never_err", 32'(err_seen), 32'h0);
    checkOutput("wd_still_stb", 32'(s_stb_o), 32'h1);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 14'h0010, 16'h0);
    nextCycle();
`endif
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 14'h0000, 16'h0);
    nextCycle();

    // Slave acks on exactly the TIMEOUT-th cycle: ack wins
    $display("[TB] ack at timeout boundary");
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 14'h0020, 16'h0);
    nextCycle();
    checkOutput("bd_grant_m0", 32'(grant_o), 32'h1);
    for (int c = 1; c <= 7; c++) nextCycle();
    s_ack_i[0] = 1'b1;
    s_dat_i[0*DW +: DW] = 16'h5A5A;
    #1;
    checkOutput("bd_ack",  32'(m_ack_o), 32'h1);
    checkOutput("bd_err",  32'(m_err_o), 32'h0);
    checkOutput("bd_data", 32'(m_dat_o[0*DW +: DW]), 32'h5A5A);
    nextCycle();
    s_ack_i[0] = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 14'h0020, 16'h0);
    #1 checkOutput("bd_no_err_after", 32'(m_err_o), 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 14'h0000, 16'h0);
    nextCycle();
    nextCycle();

    // Reset in the middle of a master-1 write with masters 0 and 2 waiting
    $display("[TB] reset mid-write");
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 14'h0800, 16'hCAFE);
    nextCycle();
    checkOutput("rs_grant_m1", 32'(grant_o), 32'h2);
    checkOutput("rs_stb",      32'(s_stb_o), 32'h2);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 14'h0000, 16'h0);
    applyStimulus(2, 1'b1, 1'b0, 1'b0, 14'h0000, 16'h0);
    #1 resetn = 1'b0;
    #1;
    checkOutput("rs_grant_zero", 32'(grant_o), 32'h0);
    checkOutput("rs_stb_zero",   32'(s_stb_o), 32'h0);
    checkOutput("rs_cyc_zero",   32'(s_cyc_o), 32'h0);
    checkOutput("rs_err_zero",   32'(m_err_o), 32'h0);
    checkOutput("rs_ack_zero",   32'(m_ack_o), 32'h0);
    nextCycle();
    checkOutput("rs_err_held", 32'(m_err_o), 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 14'h0000, 16'h0);
    resetn = 1'b1;
    nextCycle();
    checkOutput("rs_grant_lowest", 32'(grant_o), 32'h1);
    checkOutput("rs_err_after",    32'(m_err_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_xbar.md
WB_XBAR -- requirements
Module: wb_xbar

Interface
REQ-001 SHALL have parameter NUM_M, default 4, number of Wishbone masters (1..8).
REQ-002 SHALL have parameter NUM_S, default 8, number of slaves (1..16).
REQ-003 SHALL have parameter AW, default 14, address width.
REQ-004 SHALL have parameter DW, default 16, data width; SW = DW/8 select bits.
REQ-005 SHALL have parameter S_ADDR_W, default 4, number of address MSBs decoded.
REQ-006 SHALL have parameter S_BASE, default {4'hE,4'hC,4'hA,4'h8,4'h6,4'h4,4'h2,4'h0}, packed NUM_S*S_ADDR_W slave base fields, slave 0 in LSBs.
REQ-007 SHALL have parameter TIMEOUT, default 255, ack watchdog limit in cycles (1..65535).
REQ-008 clk  in  1  single system clock, all logic rising-edge.
REQ-009 resetn  in  1  asynchronous, active-low reset.
REQ-010 m_adr_i/m_dat_i/m_sel_i/m_we_i/m_cyc_i/m_stb_i  in  NUM_M*{AW,DW,SW,1,1,1}  flattened master requests, master 0 in LSBs.
REQ-011 m_dat_o/m_ack_o/m_err_o  out  NUM_M*{DW,1,1}  per-master read data, ack, error.
REQ-012 s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o  out  {AW,DW,SW,1,NUM_S,NUM_S}  shared slave request, per-slave cyc/stb.
REQ-013 s_dat_i/s_ack_i  in  NUM_S*{DW,1}  per-slave read data and ack.
REQ-014 grant_o  out  NUM_M  one-hot current grant, zero when idle.

Function
REQ-015 Arbiter SHALL be a registered FSM: IDLE, BUSY, ERR.
REQ-016 IDLE: any m_cyc_i high -> BUSY next edge, grant = first requester searching upward (mod NUM_M) from last granted index + 1.
REQ-017 Grant SHALL hold in BUSY while granted m_cyc_i is high; grant released (-> IDLE) the edge after it drops; no re-arbitration in the same cycle.
REQ-018 Shared slave outputs SHALL be combinational mux of the granted master; zero when idle.
REQ-019 Decode: slave k selected when m_adr_i[AW-1:AW-S_ADDR_W] equals S_BASE field k; lowest k wins on duplicates.
REQ-020 s_cyc_o[k]/s_stb_o[k] SHALL follow granted cyc/stb only for the selected slave, in BUSY only.
REQ-021 m_ack_o and m_dat_o of granted master SHALL be combinational from the selected slave (zero latency); other masters see 0.
REQ-022 Unmapped address with stb high in BUSY: -> ERR; m_err_o of granted master high exactly one cycle; then BUSY.
REQ-023 Watchdog counter SHALL count BUSY cycles with stb high and no ack, clear on ack, stb low, or grant change.
REQ-024 Counter reaching TIMEOUT: -> ERR, one-cycle m_err_o, slave stb forced low in ERR, counter cleared.
REQ-025 ack and timeout in the same cycle: ack wins, no error.
REQ-026 m_ack_o and m_err_o SHALL never be high together.
REQ-027 Master dropping cyc during ERR: error pulse still completes, then IDLE.

Reset
REQ-028 resetn low SHALL immediately force state IDLE, grant_o 0, last-granted index NUM_M-1, counter 0, all ack/err/stb/cyc outputs 0.
REQ-029 Reset mid-transfer SHALL abort without error pulse; first post-reset grant goes to lowest requesting index.

Configuration
REQ-030 Macro WB_XBAR_TIMEOUT_EN defined: watchdog per REQ-023/024 present.
REQ-031 Macro undefined: no counter logic synthesised, TIMEOUT ignored, stalled slave holds bus indefinitely; unmapped error unchanged.

Structure
REQ-032 Package wb_xbar_pkg SHALL hold the state enum (IDLE/BUSY/ERR) and the round-robin next-index function.
REQ-033 Sub-module wb_rr_arbiter SHALL implement NUM_M-way round-robin grant and last-index register.

Verification
REQ-034 Masters 0 and 2 assert cyc same cycle after reset -> grant_o=4'b0001; after master 0 releases, grant_o=4'b0100 two edges later.
REQ-035 Master 1 reads 0x2804 -> only s_stb_o[5] high; slave 5 returns 16'hBEEF with ack -> m_dat_o[1]=16'hBEEF, m_ack_o[1] same cycle.
REQ-036 With S_BASE slot 3 set to 4'hF, write to 0x1800 -> no s_stb_o, m_err_o one cycle, no ack.
REQ-037 TIMEOUT=8, slave never acks -> m_err_o high on 9th cycle after stb, s_stb_o low that cycle; without WB_XBAR_TIMEOUT_EN no err after 1000 cycles.
REQ-038 Slave acks on exactly cycle TIMEOUT -> ack delivered, no err.
REQ-039 resetn pulsed low mid-write -> all outputs 0 within same cycle, no err pulse, next grant to lowest requester.
